// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter.
// Bytes are accepted over a valid/ready handshake into a small FIFO and sent
// on serial_tx as: start bit, 8 data bits LSB first, optional parity bit,
// then 1 or 2 stop bits. Consecutive frames are sent with no idle gap.
//
// Ports:
//   clock      - system clock, all state on the rising edge
//   reset      - synchronous, active-high
//   tx_byte    - byte to transmit, sampled only on a push edge
//   tx_valid   - tx_byte is valid
//   tx_ready   - FIFO can accept a byte this cycle (low during reset)
//   serial_tx  - registered serial line, idle high
//   busy       - frame in progress or FIFO non-empty
//   fifo_count - bytes queued, excluding the byte being shifted out
module uart_tx_buffered #(
    parameter int unsigned CLOCKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned PARITY         = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  tx_byte,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        serial_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    logic [7:0]    head;

    assign tx_ready      = !reset && (count_q != FULL_COUNT);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_byte;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_e        state_q;
    state_e        state_d;
    logic [BW-1:0] baud_q;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          par_q;
    logic          par_d;
    logic          tx_q;
    logic          tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // State register and bit-timing datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_q == 3'd7)) begin
                    state_d = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end && (bit_q == STOP_LAST)) begin
                    state_d = fifo_nonempty ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic. serial_tx is registered, so the value for the
    // next bit is loaded on the edge that ends the current one.
    always_comb begin
        baud_d  = bit_end ? '0 : baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = ^head;
                    tx_d    = 1'b0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY == 0) begin
                            tx_d = 1'b1;
                        end else if (PARITY == 2) begin
                            tx_d = ~par_q;
                        end else begin
                            tx_d = par_q;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    tx_d  = 1'b1;
                    bit_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Zero-gap chaining: the next start bit follows the
                        // last stop bit directly when a byte is waiting.
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = ^head;
                            tx_d    = 1'b0;
                        end else begin
                            tx_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = 1'b1;
                    end
                end
            end
            default: begin
                baud_d = '0;
                tx_d   = 1'b1;
            end
        endcase
    end

    assign serial_tx  = tx_q;
    assign busy       = (state_q != IDLE) || fifo_nonempty;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered.
// Three instances at 4 clocks/bit: 8N1, 8E2 and 8O1.
module tb_uart_tx_buffered;

    localparam int CPB = 4;

    typedef struct {
        int          unit;
        logic [7:0]  data;
        logic [11:0] bits;    // bit k = k-th bit on the line (start first)
        int          cycles;  // frame length in clocks
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_byte;
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] stx;
    logic [2:0] bsy;
    logic [2:0] cnt [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_tx_buffered #(
        .CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY(0)
    ) u_8n1 (
        .clock(clock), .reset(reset), .tx_byte(tx_byte), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .serial_tx(stx[0]), .busy(bsy[0]), .fifo_count(cnt[0])
    );

    uart_tx_buffered #(
        .CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(2), .PARITY(1)
    ) u_8e2 (
        .clock(clock), .reset(reset), .tx_byte(tx_byte), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .serial_tx(stx[1]), .busy(bsy[1]), .fifo_count(cnt[1])
    );

    uart_tx_buffered #(
        .CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4), .STOP_BITS(1), .PARITY(2)
    ) u_8o1 (
        .clock(clock), .reset(reset), .tx_byte(tx_byte), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .serial_tx(stx[2]), .busy(bsy[2]), .fifo_count(cnt[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Line decoder for the 8N1 instance: samples mid-bit after a start bit.
    logic       mon_en = 1'b0;
    logic [7:0] mon_b;
    int         mon_t0;
    logic [7:0] rx_q [$];
    int         st_q [$];

    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (mon_en && !reset && stx[0] == 1'b0) begin
                mon_t0 = cyc;
                repeat (CPB / 2) @(posedge clock);
                #2;
                chk("mon_start_mid", stx[0], 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(posedge clock);
                    #2;
                    mon_b[k] = stx[0];
                end
                repeat (CPB) @(posedge clock);
                #2;
                chk("mon_stop_bit", stx[0], 1);
                rx_q.push_back(mon_b);
                st_q.push_back(mon_t0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t       vecs [7];
    logic [7:0] burst_data [5];
    int         burst_cnt [5];
    logic [7:0] exp_seq [6];
    int         u;

    initial begin
        vecs[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 40};
        vecs[1] = '{0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 40};
        vecs[2] = '{0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}, 40};
        vecs[3] = '{1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 48};
        vecs[4] = '{1, 8'h81, {2'b11, 1'b0, 8'h81, 1'b0}, 48};
        vecs[5] = '{2, 8'h03, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 44};
        vecs[6] = '{2, 8'h80, {1'b0, 1'b1, 1'b0, 8'h80, 1'b0}, 44};

        burst_data = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81};
        burst_cnt  = '{1, 1, 2, 3, 4};
        exp_seq    = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81, 8'h6A};

        reset   = 1'b1;
        tx_byte = 8'h00;
        vld     = 3'b000;

        // Reset held for 3 cycles, then idle
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_serial_%0d", i), stx, 3'b111);
            chk($sformatf("rst_busy_%0d", i), bsy, 3'b000);
            chk($sformatf("rst_ready_%0d", i), rdy, 3'b000);
            chk($sformatf("rst_count_%0d", i), cnt[0], 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle_ready_%0d", i), rdy, 3'b111);
            chk($sformatf("idle_serial_%0d", i), stx, 3'b111);
            chk($sformatf("idle_busy_%0d", i), bsy, 3'b000);
            chk($sformatf("idle_count_%0d", i), cnt[0], 0);
        end

        // Single-frame vectors
        foreach (vecs[i]) begin
            u          = vecs[i].unit;
            tx_byte    = vecs[i].data;
            vld[u]     = 1'b1;
            step();
            vld[u]     = 1'b0;
            chk($sformatf("vec%0d_count_after_push", i), cnt[u], 1);
            chk($sformatf("vec%0d_busy_after_push", i), bsy[u], 1);
            chk($sformatf("vec%0d_serial_before_start", i), stx[u], 1);
            step();
            for (int k = 0; k < vecs[i].cycles; k++) begin
                chk($sformatf("vec%0d_serial_c%0d", i, k), stx[u], vecs[i].bits[k / CPB]);
                if (k == vecs[i].cycles - 1) begin
                    chk($sformatf("vec%0d_busy_last", i), bsy[u], 1);
                end
                step();
            end
            chk($sformatf("vec%0d_busy_end", i), bsy[u], 0);
            chk($sformatf("vec%0d_serial_end", i), stx[u], 1);
        end
        repeat (3) step();

        // Back-to-back burst into a 4-deep FIFO, then stall with changing data
        rx_q.delete();
        st_q.delete();
        mon_en = 1'b1;
        vld[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_byte = burst_data[i];
            step();
            chk($sformatf("burst_count_%0d", i), cnt[0], burst_cnt[i]);
        end
        chk("burst_ready_full", rdy[0], 0);
        chk("burst_busy", bsy[0], 1);
        for (int j = 5; j <= 50; j++) begin
            tx_byte = 8'h40 + 8'(j);
            step();
            chk($sformatf("stall_ready_%0d", j), rdy[0], (j == 41) ? 1 : 0);
            chk($sformatf("stall_count_%0d", j), cnt[0], (j == 41) ? 3 : 4);
        end
        vld[0] = 1'b0;
        for (int w = 0; w < 400 && rx_q.size() < 6; w++) step();
        chk("burst_frames", rx_q.size(), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            chk($sformatf("burst_byte_%0d", i), rx_q[i], exp_seq[i]);
        end
        for (int i = 1; i < st_q.size(); i++) begin
            chk($sformatf("burst_gap_%0d", i), st_q[i] - st_q[i-1], 40);
        end
        for (int w = 0; w < 20 && bsy[0] !== 1'b0; w++) step();
        chk("burst_busy_end", bsy[0], 0);
        chk("burst_count_end", cnt[0], 0);
        mon_en = 1'b0;
        repeat (3) step();

        // Reset during data bit d3 of 0x3C with two bytes queued
        vld[0]  = 1'b1;
        tx_byte = 8'h3C;
        step();
        tx_byte = 8'h11;
        step();
        tx_byte = 8'h22;
        step();
        vld[0]  = 1'b0;
        chk("abort_count_queued", cnt[0], 2);
        repeat (8) step();
        chk("abort_d1", stx[0], 0);
        repeat (8) step();
        chk("abort_d3", stx[0], 1);
        chk("abort_busy_before", bsy[0], 1);
        reset = 1'b1;
        step();
        chk("abort_serial", stx[0], 1);
        chk("abort_count", cnt[0], 0);
        chk("abort_busy", bsy[0], 0);
        chk("abort_ready", rdy[0], 0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            chk($sformatf("post_abort_serial_%0d", i), stx[0], 1);
            chk($sformatf("post_abort_busy_%0d", i), bsy[0], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter: the transmit end of the serial link whose receive side feeds the board's rx_byte path.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte onto serial_tx as an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Sits between on-chip byte producers and the board TX pin; sustains back-to-back frames with no inter-frame gap.

Parameters:
- CLOCKS_PER_BIT, 104, clock cycles per serial bit (legal range 2..65535).
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- tx_byte  input  8  byte to transmit.
- tx_valid  input  1  tx_byte valid.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- serial_tx  output  1  serial line, idle high; registered output.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

Behaviour:
- Interface: clock clock; reset reset, synchronous, active-high.
- Reset values:
  - serial_tx = 1, busy = 0, fifo_count = 0, tx_ready = 0 while reset is asserted.
  - FSM returns to IDLE; FIFO pointers and baud/bit counters are cleared.
- Reset mid-frame aborts the frame and flushes the FIFO; serial_tx is high from the first edge with reset sampled.
- tx_ready = !reset && (fifo_count != FIFO_DEPTH); it is a combinational function of registered count only, never of tx_valid.
- Push occurs when tx_valid && tx_ready at a rising edge.
  - tx_valid while not ready is ignored; the producer must hold tx_byte.
  - tx_byte is sampled only on a push edge.
- Pop: the FSM pops the FIFO head into an internal shift register.
- Simultaneous push and pop leaves fifo_count unchanged. Push while full is impossible because ready is low. Pop while empty never occurs.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE, FIFO non-empty at edge E: pop, compute parity, serial_tx <= 0, go to START. The start bit therefore begins the cycle after E. A byte pushed into an empty idle block at edge N is popped at edge N+1.
  - Each bit holds serial_tx for exactly CLOCKS_PER_BIT cycles, timed by a baud counter reloaded at every bit boundary.
  - START -> DATA: bits d0..d7 in order, LSB first, each for one bit period.
  - DATA -> PAR if PARITY != 0, else -> STOP.
    - PAR drives even parity (XOR of data) for PARITY=1, or its inverse for PARITY=2.
  - STOP drives 1 for STOP_BITS bit periods.
  - At the end of the final stop period: if the FIFO is non-empty, pop and go directly to START with serial_tx <= 0 (zero-gap back-to-back); else go to IDLE.
- Frame length: exactly (9 + (PARITY!=0) + STOP_BITS) * CLOCKS_PER_BIT cycles, start edge to next possible start edge.
- busy = (state != IDLE) || (fifo_count != 0). It deasserts on the edge where the FSM enters IDLE with an empty FIFO.
- Counter widths are sized from the parameters; no counter may wrap within a legal frame.
- FIFO read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset and idle (CLOCKS_PER_BIT=4): hold reset 3 cycles, then release with no traffic → serial_tx=1, busy=0, fifo_count=0 throughout; tx_ready=0 during reset and 1 after.
- Single byte, 8N1 (CLOCKS_PER_BIT=4): push 0xA5 at edge N → serial_tx low for 4 cycles starting the cycle after edge N+1. Then data bits 1,0,1,0,0,1,0,1, each 4 cycles, then high for 4 cycles. Total 40 cycles; busy drops afterwards.
- Back-to-back, FIFO full: push 0x00, 0xFF, 0x55, 0x0F, 0x81 on consecutive cycles with FIFO_DEPTH=4 →
  - tx_ready falls once 4 bytes are queued while the first is in flight, and the 5th is accepted only after the first pop.
  - All five frames are emitted with no idle cycles between stop bit and next start bit.
  - The decoded sequence matches the push order.
- Parity and stop bits: PARITY=1, STOP_BITS=2, send 0x07 → parity bit 1 and frame length 48 cycles at CLOCKS_PER_BIT=4. PARITY=2, send 0x03 → parity bit 1.
- Reset mid-frame: assert reset during data bit d3 of 0x3C with 2 bytes queued → serial_tx=1 next edge, fifo_count=0. After release with no new pushes, no further frames are emitted.
- Handshake stall: hold tx_valid high with a changing tx_byte while full → only bytes present on push edges are transmitted; no duplicates, no drops.
